// File: rtl/eth_sw_pkg.sv
// Shared types and default sizing for the multi-port packet switch.
package eth_sw_pkg;

   localparam int unsigned DefNumPorts  = 4;
   localparam int unsigned DefDataW     = 64;
   localparam int unsigned DefFifoDepth = 16;

   typedef enum logic {
      StIdle,
      StXfer
   } arb_state_e;

endpackage

// File: rtl/eth_pkt_fifo.sv
// Per-port store-and-forward packet buffer with rewind on drop and a complete-packet count.
module eth_pkt_fifo
   import eth_sw_pkg::*;
#(
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              wr_vld,
   input  logic              wr_sop,
   input  logic              wr_eop,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_sop,
   output logic              rd_eop,
   output logic              pkt_avail,
   output logic              drop
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PtrOne = 1;

   logic [DATA_W+1:0] mem [FIFO_DEPTH];

   logic [AW:0] wr_ptr_q, rd_ptr_q, start_ptr_q;
   logic [AW:0] cnt_q;
   logic        in_pkt_q, drop_q;

   logic        accept, restart, wr_full, do_write, do_drop, cnt_inc, cnt_dec;
   logic [AW:0] wr_base, used;

   always_comb begin
      accept   = wr_vld & (wr_sop | in_pkt_q);
      restart  = wr_vld & wr_sop & in_pkt_q;
      // A restarting packet overwrites the aborted one, so fullness is measured from its start.
      wr_base  = restart ? start_ptr_q : wr_ptr_q;
      used     = wr_base - rd_ptr_q;
      wr_full  = used[AW];
      do_write = accept & ~wr_full;
      do_drop  = restart | (accept & wr_full);
      cnt_inc  = do_write & wr_eop;
      cnt_dec  = rd_en & rd_eop;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         start_ptr_q <= '0;
         cnt_q       <= '0;
         in_pkt_q    <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         drop_q <= do_drop;
         if (do_write) begin
            wr_ptr_q <= wr_base + PtrOne;
            if (wr_sop) begin
               start_ptr_q <= wr_base;
            end
            in_pkt_q <= ~wr_eop;
         end else if (accept) begin
            // Overflow: forget the partial packet; its remaining beats lack sop and fall away.
            if (in_pkt_q) begin
               wr_ptr_q <= start_ptr_q;
            end
            in_pkt_q <= 1'b0;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         if (cnt_inc && !cnt_dec) begin
            cnt_q <= cnt_q + PtrOne;
         end else if (cnt_dec && !cnt_inc) begin
            cnt_q <= cnt_q - PtrOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_base[AW-1:0]] <= {wr_sop, wr_eop, wr_data};
      end
   end

   assign {rd_sop, rd_eop, rd_data} = mem[rd_ptr_q[AW-1:0]];
   assign pkt_avail = (cnt_q != '0);
   assign drop      = drop_q;

endmodule

// File: rtl/eth_sw_mp.sv
// Multi-port packet switch: per-port packet FIFOs merged onto one output by a round-robin arbiter.
module eth_sw_mp
   import eth_sw_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = DefNumPorts,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic [NUM_PORTS*DATA_W-1:0] inData,
   input  logic [NUM_PORTS-1:0]        inSop,
   input  logic [NUM_PORTS-1:0]        inEop,
   input  logic [NUM_PORTS-1:0]        inVld,
   output logic [DATA_W-1:0]           outData,
   output logic                        outSop,
   output logic                        outEop,
   output logic                        outvld,
   input  logic                        outRdy,
   output logic [NUM_PORTS-1:0]        pktDrop
);

   localparam int unsigned GW = $clog2(NUM_PORTS);

   arb_state_e state_q, state_d;
   logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick, sel, cand;
   logic          pick_vld, rd, out_ld;
   int unsigned   idx;

   logic [NUM_PORTS-1:0] avail, rd_en, f_sop, f_eop;
   logic [DATA_W-1:0]    f_data [NUM_PORTS];

   logic [DATA_W-1:0] out_data_q;
   logic              out_sop_q, out_eop_q, out_vld_q;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      eth_pkt_fifo #(
         .DATA_W    (DATA_W),
         .FIFO_DEPTH(FIFO_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .resetN   (resetN),
         .wr_vld   (inVld[p]),
         .wr_sop   (inSop[p]),
         .wr_eop   (inEop[p]),
         .wr_data  (inData[p*DATA_W +: DATA_W]),
         .rd_en    (rd_en[p]),
         .rd_data  (f_data[p]),
         .rd_sop   (f_sop[p]),
         .rd_eop   (f_eop[p]),
         .pkt_avail(avail[p]),
         .drop     (pktDrop[p])
      );
   end

   // Descending scan so the port closest after last_q wins.
   always_comb begin
      pick     = last_q;
      pick_vld = 1'b0;
      idx      = 0;
      cand     = '0;
      for (int unsigned i = NUM_PORTS; i >= 1; i--) begin
         idx  = (32'(last_q) + i) % NUM_PORTS;
         cand = GW'(idx);
         if (avail[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      sel     = grant_q;
      rd      = 1'b0;
      out_ld  = ~out_vld_q | outRdy;
      case (state_q)
         StIdle: begin
            if (pick_vld && out_ld) begin
               sel     = pick;
               rd      = 1'b1;
               grant_d = pick;
               last_d  = pick;
               state_d = StXfer;
            end
         end
         StXfer: begin
            // Once the eop beat sits in the output register, stop reading until it leaves.
            if (out_vld_q && out_eop_q) begin
               if (outRdy) begin
                  state_d = StIdle;
               end
            end else if (out_ld) begin
               rd = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_en = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         rd_en[i] = rd && (sel == GW'(i));
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= GW'(NUM_PORTS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         out_data_q <= '0;
         out_sop_q  <= 1'b0;
         out_eop_q  <= 1'b0;
         out_vld_q  <= 1'b0;
      end else if (out_ld) begin
         out_vld_q <= rd;
         out_sop_q <= rd & f_sop[sel];
         out_eop_q <= rd & f_eop[sel];
         if (rd) begin
            out_data_q <= f_data[sel];
         end
      end
   end

   assign outData = out_data_q;
   assign outSop  = out_sop_q;
   assign outEop  = out_eop_q;
   assign outvld  = out_vld_q;

endmodule

// File: tb/tb_eth_sw_mp.sv
// Directed self-checking bench for eth_sw_mp with 4 ports, 64-bit beats, 16-deep FIFOs.
module tb_eth_sw_mp;

   localparam int NP = 4;
   localparam int DW = 64;

   logic             clk = 1'b0;
   logic             resetN;
   logic [NP*DW-1:0] inData;
   logic [NP-1:0]    inSop, inEop, inVld;
   logic [DW-1:0]    outData;
   logic             outSop, outEop, outvld, outRdy;
   logic [NP-1:0]    pktDrop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   eth_sw_mp #(
      .NUM_PORTS (NP),
      .DATA_W    (DW),
      .FIFO_DEPTH(16)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .inData (inData),
      .inSop  (inSop),
      .inEop  (inEop),
      .inVld  (inVld),
      .outData(outData),
      .outSop (outSop),
      .outEop (outEop),
      .outvld (outvld),
      .outRdy (outRdy),
      .pktDrop(pktDrop)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic [63:0] d, input logic s, input logic e);
      inData[p*DW +: DW] = d;
      inSop[p] = s;
      inEop[p] = e;
      inVld[p] = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      inVld = '0;
      inSop = '0;
      inEop = '0;
   endtask

   // Waits (bounded) for a transferring beat, checks it, then lets it transfer.
   task automatic expect_beat(input string tag, input logic [63:0] d, input logic s,
                              input logic e);
      int n = 0;
      while (!(outvld && outRdy) && n < 20) begin
         step();
         n++;
      end
      check({tag, "_timeout"}, 64'(n < 20), 64'd1);
      check({tag, "_data"}, outData, d);
      check({tag, "_sop"}, 64'(outSop), 64'(s));
      check({tag, "_eop"}, 64'(outEop), 64'(e));
      step();
   endtask

   initial begin
      int drop_cnt, out_cnt, n_got;
      logic          hold_pend;
      logic [63:0]   held;
      logic [63:0]   got [4];
      logic          got_eop [4];

      resetN = 1'b0;
      outRdy = 1'b1;
      inData = '0;
      inSop  = '0;
      inEop  = '0;
      inVld  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outvld", 64'(outvld), 64'd0);
      check("rst_outsop", 64'(outSop), 64'd0);
      check("rst_outeop", 64'(outEop), 64'd0);
      check("rst_outdata", outData, 64'd0);
      check("rst_pktdrop", 64'(pktDrop), 64'd0);
      resetN = 1'b1;
      step();

      // All four ports, one single-beat packet each, twice.
      for (int p = 0; p < NP; p++) drive(p, 64'hB0 + 64'(p), 1'b1, 1'b1);
      step();
      for (int p = 0; p < NP; p++) expect_beat($sformatf("rr1_p%0d", p), 64'hB0 + 64'(p), 1, 1);
      for (int p = 0; p < NP; p++) drive(p, 64'hC0 + 64'(p), 1'b1, 1'b1);
      step();
      for (int p = 0; p < NP; p++) expect_beat($sformatf("rr2_p%0d", p), 64'hC0 + 64'(p), 1, 1);
      repeat (3) step();
      check("rr_idle", 64'(outvld), 64'd0);

      // Port 0 three-beat packet: exact latency and contiguity.
      drive(0, 64'hA1, 1'b1, 1'b0);
      step();
      drive(0, 64'hA2, 1'b0, 1'b0);
      step();
      drive(0, 64'hA3, 1'b0, 1'b1);
      step();
      check("lat_t1_vld", 64'(outvld), 64'd0);
      step();
      check("lat_t2_vld", 64'(outvld), 64'd1);
      check("lat_t2_sop", 64'(outSop), 64'd1);
      check("lat_t2_data", outData, 64'hA1);
      step();
      check("lat_b2_vld", 64'(outvld), 64'd1);
      check("lat_b2_data", outData, 64'hA2);
      check("lat_b2_eop", 64'(outEop), 64'd0);
      step();
      check("lat_b3_data", outData, 64'hA3);
      check("lat_b3_eop", 64'(outEop), 64'd1);
      step();
      check("lat_done_vld", 64'(outvld), 64'd0);

      // Port 1 oversize packet is dropped; following packet passes.
      drop_cnt = 0;
      out_cnt  = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1, 64'h100 + 64'(i), 1'(i == 0), 1'(i == 19));
         step();
         drop_cnt += int'(pktDrop[1]);
         out_cnt  += int'(outvld);
      end
      repeat (4) begin
         step();
         drop_cnt += int'(pktDrop[1]);
         out_cnt  += int'(outvld);
      end
      check("ovf_drops", 64'(drop_cnt), 64'd1);
      check("ovf_no_out", 64'(out_cnt), 64'd0);
      drive(1, 64'hD1, 1'b1, 1'b0);
      step();
      drive(1, 64'hD2, 1'b0, 1'b1);
      step();
      expect_beat("ovf_next_b1", 64'hD1, 1, 0);
      expect_beat("ovf_next_b2", 64'hD2, 0, 1);

      // Port 2 sop inside a packet restarts it.
      drop_cnt = 0;
      drive(2, 64'hE1, 1'b1, 1'b0);
      step();
      drop_cnt += int'(pktDrop[2]);
      drive(2, 64'hE2, 1'b0, 1'b0);
      step();
      drop_cnt += int'(pktDrop[2]);
      drive(2, 64'hF1, 1'b1, 1'b0);
      step();
      drop_cnt += int'(pktDrop[2]);
      drive(2, 64'hF2, 1'b0, 1'b1);
      step();
      drop_cnt += int'(pktDrop[2]);
      check("rst_pkt_drops", 64'(drop_cnt), 64'd1);
      expect_beat("rst_pkt_b1", 64'hF1, 1, 0);
      expect_beat("rst_pkt_b2", 64'hF2, 0, 1);
      repeat (3) step();
      check("rst_pkt_idle", 64'(outvld), 64'd0);

      // Port 3 four-beat packet under toggling backpressure.
      outRdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(3, 64'h31 + 64'(i), 1'(i == 0), 1'(i == 3));
         step();
      end
      hold_pend = 1'b0;
      held      = '0;
      n_got     = 0;
      for (int c = 0; c < 40 && n_got < 4; c++) begin
         if (hold_pend) begin
            check("bp_hold_vld", 64'(outvld), 64'd1);
            check("bp_hold_data", outData, held);
            hold_pend = 1'b0;
         end
         outRdy = 1'((c % 2) == 1);
         if (outvld && outRdy) begin
            got[n_got]     = outData;
            got_eop[n_got] = outEop;
            n_got++;
         end else if (outvld) begin
            hold_pend = 1'b1;
            held      = outData;
         end
         step();
      end
      outRdy = 1'b1;
      check("bp_count", 64'(n_got), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_beat%0d", i), got[i], 64'h31 + 64'(i));
         check($sformatf("bp_eop%0d", i), 64'(got_eop[i]), 64'(i == 3));
      end

      // Reset in the middle of a six-beat transfer.
      for (int i = 0; i < 6; i++) begin
         drive(0, 64'h61 + 64'(i), 1'(i == 0), 1'(i == 5));
         step();
      end
      expect_beat("mid_b1", 64'h61, 1, 0);
      expect_beat("mid_b2", 64'h62, 0, 0);
      check("mid_pre_vld", 64'(outvld), 64'd1);
      resetN = 1'b0;
      #1;
      check("mid_rst_vld", 64'(outvld), 64'd0);
      check("mid_rst_data", outData, 64'd0);
      check("mid_rst_sop", 64'(outSop), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
      out_cnt = 0;
      repeat (10) begin
         step();
         out_cnt += int'(outvld);
      end
      check("mid_no_residual", 64'(out_cnt), 64'd0);
      drive(0, 64'h77, 1'b0, 1'b1);
      step();
      out_cnt = 0;
      repeat (6) begin
         step();
         out_cnt += int'(outvld);
      end
      check("mid_nosop_discard", 64'(out_cnt), 64'd0);
      drive(0, 64'h88, 1'b1, 1'b1);
      step();
      expect_beat("mid_after", 64'h88, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eth_sw_mp.md
ETH_SW_MP -- requirements
Module: eth_sw_mp

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of input ports (2..8).
REQ-002 Parameter DATA_W, default 64, beat width in bits.
REQ-003 Parameter FIFO_DEPTH, default 16, per-port buffer depth in beats, power of two.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 inData  input  NUM_PORTS*DATA_W  per-port beat data, port p at bits [p*DATA_W +: DATA_W].
REQ-007 inSop  input  NUM_PORTS  per-port start-of-packet, qualified by inVld.
REQ-008 inEop  input  NUM_PORTS  per-port end-of-packet, qualified by inVld.
REQ-009 inVld  input  NUM_PORTS  per-port beat valid; no input backpressure.
REQ-010 outData  output  DATA_W  output beat data.
REQ-011 outSop  output  1  output start-of-packet, qualified by outvld.
REQ-012 outEop  output  1  output end-of-packet, qualified by outvld.
REQ-013 outvld  output  1  output beat valid.
REQ-014 outRdy  input  1  downstream ready; beat transfers when outvld and outRdy are both high.
REQ-015 pktDrop  output  NUM_PORTS  one-cycle pulse per dropped packet, per port.

Function
REQ-016 Each port SHALL buffer beats in its own FIFO, store-and-forward: a packet is eligible only after its eop beat is written.
REQ-017 Beat with inSop and inEop both high SHALL be a complete single-beat packet.
REQ-018 Valid beat without inSop while port is not inside a packet SHALL be discarded, no pktDrop.
REQ-019 inSop while inside a packet SHALL rewind write pointer to saved packet-start pointer, pulse pktDrop, and start the new packet with this beat.
REQ-020 Write to a full FIFO SHALL rewind write pointer to packet-start, pulse pktDrop next cycle, and discard remaining beats up to and including eop.
REQ-021 Per-port complete-packet count SHALL increment on eop write, decrement when that packet's eop is read; simultaneous events leave it unchanged.
REQ-022 Arbiter FSM states: IDLE, XFER.
REQ-023 IDLE -> XFER when any port has count > 0; grant chosen round-robin starting at port after last granted (port 0 first after reset).
REQ-024 XFER -> IDLE on transfer of the eop beat; no port switch inside a packet.
REQ-025 Output registers SHALL hold outData/outSop/outEop/outvld stable while outvld high and outRdy low.
REQ-026 Latency: eop written in cycle t with output idle and outRdy high SHALL give outSop/outvld of that packet in cycle t+2.
REQ-027 With outRdy held high, a granted packet SHALL stream one beat per cycle with no gaps.
REQ-028 Back-to-back packets SHALL have at most one idle cycle between outEop and next outSop.
REQ-029 Full/empty SHALL use pointers one bit wider than log2(FIFO_DEPTH); wrap-around needs no special handling.

Reset
REQ-030 resetN low SHALL asynchronously clear outvld, outSop, outEop, pktDrop, all pointers, counts, in-packet flags; outData to 0; FSM to IDLE; round-robin pointer to port 0.
REQ-031 Reset mid-packet SHALL discard all buffered data; first post-reset beat accepted only with inSop.

Structure
REQ-032 Shared package eth_sw_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Per-port buffering SHALL be sub-module eth_pkt_fifo (write/rewind/read, packet count), instantiated NUM_PORTS times via generate.

Verification
REQ-034 Port 0 sends 3-beat packet 0xA1,0xA2,0xA3, outRdy=1 -> outSop with 0xA1 two cycles after eop, outEop on 0xA3, contiguous.
REQ-035 All 4 ports send 1-beat packet same cycle -> output order port 0,1,2,3; repeat -> order 0,1,2,3 again.
REQ-036 Port 1 sends 20-beat packet, FIFO_DEPTH=16 -> pktDrop[1] pulse once, nothing output, next 2-beat packet forwarded intact.
REQ-037 Port 2 sop, 2 beats, sop again, 1 beat, eop -> pktDrop[2] once, only 2-beat second packet forwarded.
REQ-038 outRdy toggled 1/0 every cycle during 4-beat packet -> each beat held stable while outRdy low, all 4 beats in order.
REQ-039 resetN low mid-transfer of 6-beat packet -> outvld 0 immediately, no residual beats after resetN high.
